// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 square-root result path.
// Operand classes, flag bit positions and special encodings.
package fpu_pkg;

  typedef enum logic [2:0] {
    SQRT_NORMAL  = 3'd0,
    SQRT_ZERO    = 3'd1,
    SQRT_INF     = 3'd2,
    SQRT_QNAN    = 3'd3,
    SQRT_INVALID = 3'd4
  } sqrt_class_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  // Legacy integrations expect an all-ones NaN instead of the canonical quiet NaN.
  function automatic logic [31:0] nan_encoding(input bit canonical);
    return canonical ? FP32_QNAN : 32'hFFFF_FFFF;
  endfunction

endpackage

// File: rtl/fpu_sqrt_round_if.sv
// Handshake and result bundle between the sqrt core, the rounding stage and writeback.
interface fpu_sqrt_round_if;
  import fpu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  sqrt_class_t in_class;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_root;
  logic        in_rem_nz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clear;

  modport slave (
    input  in_valid, in_class, in_sign, in_exp, in_root, in_rem_nz, out_ready, fflags_clear,
    output in_ready, out_valid, out_result, out_flags, fflags
  );

  modport master (
    output in_valid, in_class, in_sign, in_exp, in_root, in_rem_nz, out_ready, fflags_clear,
    input  in_ready, out_valid, out_result, out_flags, fflags
  );

endinterface

// File: rtl/fpu_result_fifo.sv
// Two-entry in-order valid/ready FIFO; push ready ignores pop ready so the
// producer never combinationally depends on writeback.
module fpu_result_fifo #(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld_i,
  output logic             push_rdy_o,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_dat_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push;
  logic             pop;

  assign push_rdy_o = !rst && (count_q < 2'd2);
  assign pop_vld_o  = (count_q != 2'd0);
  assign pop_dat_o  = mem_q[rd_ptr_q];
  assign push       = push_vld_i && push_rdy_o;
  assign pop        = pop_vld_o && pop_rdy_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
  end

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpu_sqrt_round.sv
// Round-to-nearest-even and IEEE packing of the sqrt root, buffered in a 2-entry
// FIFO (1-cycle latency, in_ready independent of out_ready), plus sticky fflags.
module fpu_sqrt_round
  import fpu_pkg::*;
#(
  parameter bit CANONICAL_NAN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  fpu_sqrt_round_if.slave io
);

  localparam logic [31:0] NAN_ENC = nan_encoding(CANONICAL_NAN);

  logic [23:0] sig;
  logic        guard;
  logic        lsb;
  logic        rnd_up;
  logic [24:0] sig_sum;
  logic        hidden_unused;
  logic [7:0]  exp_rnd;
  logic [31:0] result;
  logic [4:0]  flags;
  logic [4:0]  new_flags;
  logic [4:0]  fflags_q, fflags_d;
  logic        push_rdy;
  logic        accept;
  logic [36:0] head;

  assign sig    = io.in_root[24:1];
  assign guard  = io.in_root[0];
  assign lsb    = io.in_root[1];
  assign rnd_up = guard && (io.in_rem_nz || lsb);

  // A carry out of the 24-bit significand leaves the fraction at zero and bumps the exponent.
  assign sig_sum       = {1'b0, sig} + {24'd0, rnd_up};
  assign hidden_unused = sig_sum[23];
  assign exp_rnd       = io.in_exp + {7'd0, sig_sum[24]};

  always_comb begin
    result = NAN_ENC;
    flags  = '0;
    case (io.in_class)
      SQRT_NORMAL: begin
        result         = {1'b0, exp_rnd, sig_sum[22:0]};
        flags[FLAG_NX] = guard | io.in_rem_nz;
      end
      SQRT_ZERO: result = {io.in_sign, 31'd0};
      SQRT_INF:  result = FP32_PINF;
      SQRT_QNAN: result = NAN_ENC;
      default: begin
        result         = NAN_ENC;
        flags[FLAG_NV] = 1'b1;
      end
    endcase
  end

  assign accept      = io.in_valid && push_rdy;
  assign new_flags   = accept ? flags : 5'd0;
  assign fflags_d    = io.fflags_clear ? new_flags : (fflags_q | new_flags);
  assign io.in_ready = push_rdy;
  assign io.fflags   = fflags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  fpu_result_fifo #(
    .WIDTH(37)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld_i(io.in_valid),
    .push_rdy_o(push_rdy),
    .push_dat_i({result, flags}),
    .pop_vld_o (io.out_valid),
    .pop_rdy_i (io.out_ready),
    .pop_dat_o (head)
  );

  assign io.out_result = head[36:5];
  assign io.out_flags  = head[4:0];

endmodule

// File: tb/tb_fpu_sqrt_round.sv
// Directed bench for the sqrt rounding/packing stage: rounding, specials,
// NaN encoding options, backpressure ordering, sticky flags and reset flush.
module tb_fpu_sqrt_round;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fpu_sqrt_round_if bus();
  fpu_sqrt_round_if bus_l();

  fpu_sqrt_round #(.CANONICAL_NAN(1'b1)) dut (.clk(clk), .rst(rst), .io(bus));
  fpu_sqrt_round #(.CANONICAL_NAN(1'b0)) dut_legacy (.clk(clk), .rst(rst), .io(bus_l));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_op(input sqrt_class_t c, input logic s, input logic [7:0] e,
                          input logic [24:0] r, input logic nz);
    bus.in_class  = c;
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_root   = r;
    bus.in_rem_nz = nz;
    bus.in_valid  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.fflags_clear = 1'b0;
    bus.in_class = SQRT_NORMAL; bus.in_sign = 1'b0; bus.in_exp = 8'h00;
    bus.in_root = 25'd0; bus.in_rem_nz = 1'b0;
    bus_l.in_valid = 1'b0; bus_l.out_ready = 1'b1; bus_l.fflags_clear = 1'b0;
    bus_l.in_class = SQRT_NORMAL; bus_l.in_sign = 1'b0; bus_l.in_exp = 8'h00;
    bus_l.in_root = 25'd0; bus_l.in_rem_nz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 00000000", bus.out_result); end
    checks++; if (bus.out_flags !== 5'b0) begin errors++; $display("FAIL reset_out_flags: got %b expected 00000", bus.out_flags); end
    checks++; if (bus.fflags !== 5'b0) begin errors++; $display("FAIL reset_fflags: got %b expected 00000", bus.fflags); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_rounding();
    logic [7:0]  e   [6] = '{8'h83, 8'h7F, 8'h7F, 8'h80, 8'h7F, 8'h7F};
    logic [24:0] r   [6] = '{{24'hC80000, 1'b0}, {24'hB504F3, 1'b1}, {24'hB504F3, 1'b0},
                             {24'hFFFFFF, 1'b1}, {24'hB504F2, 1'b1}, {24'hB504F3, 1'b1}};
    logic        nz  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exr [6] = '{32'h41C80000, 32'h3FB504F4, 32'h3FB504F3,
                             32'h40800000, 32'h3FB504F2, 32'h3FB504F4};
    logic [4:0]  exf [6] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_op(SQRT_NORMAL, 1'b0, e[i], r[i], nz[i]);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_result !== exr[i]) begin errors++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, bus.out_result, exr[i]); end
      checks++; if (bus.out_flags !== exf[i]) begin errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, bus.out_flags, exf[i]); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_specials();
    sqrt_class_t c   [5] = '{SQRT_INVALID, SQRT_ZERO, SQRT_ZERO, SQRT_INF, SQRT_QNAN};
    logic        s   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exr [5] = '{32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'h7FC00000};
    logic [4:0]  exf [5] = '{5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // Exponent, root and remainder are garbage: specials must ignore them.
      drive_op(c[i], s[i], 8'hAA, 25'h1FFFFFF, 1'b1);
      step();
      checks++; if (bus.out_result !== exr[i]) begin errors++; $display("FAIL spc_result[%0d]: got %h expected %h", i, bus.out_result, exr[i]); end
      checks++; if (bus.out_flags !== exf[i]) begin errors++; $display("FAIL spc_flags[%0d]: got %b expected %b", i, bus.out_flags, exf[i]); end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_legacy_nan();
    bus_l.in_class = SQRT_INVALID; bus_l.in_valid = 1'b1;
    step();
    checks++; if (bus_l.out_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL legacy_inv_result: got %h expected ffffffff", bus_l.out_result); end
    checks++; if (bus_l.out_flags !== 5'b10000) begin errors++; $display("FAIL legacy_inv_flags: got %b expected 10000", bus_l.out_flags); end
    bus_l.in_class = SQRT_QNAN;
    step();
    checks++; if (bus_l.out_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL legacy_qnan_result: got %h expected ffffffff", bus_l.out_result); end
    checks++; if (bus_l.out_flags !== 5'b00000) begin errors++; $display("FAIL legacy_qnan_flags: got %b expected 00000", bus_l.out_flags); end
    bus_l.in_valid = 1'b0;
    step();
    checks++; if (bus_l.fflags !== 5'b10000) begin errors++; $display("FAIL legacy_fflags: got %b expected 10000", bus_l.fflags); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_op(SQRT_ZERO, 1'b1, 8'h00, 25'd0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_empty: got %b expected 1", bus.in_ready); end
    step();
    checks++; if (bus.out_result !== 32'h80000000) begin errors++; $display("FAIL bp_head_a: got %h expected 80000000", bus.out_result); end
    drive_op(SQRT_INF, 1'b0, 8'h00, 25'd0, 1'b0);
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", bus.in_ready); end
    drive_op(SQRT_NORMAL, 1'b0, 8'h83, {24'hC80000, 1'b0}, 1'b0);
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_result !== 32'h80000000) begin errors++; $display("FAIL bp_head_stable: got %h expected 80000000", bus.out_result); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stalled: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_result !== 32'h7F800000) begin errors++; $display("FAIL bp_out_b: got %h expected 7f800000", bus.out_result); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen: got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_result !== 32'h41C80000) begin errors++; $display("FAIL bp_out_c: got %h expected 41c80000", bus.out_result); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c: got %b expected 1", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_sticky();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0; bus.fflags_clear = 1'b1;
    step();
    checks++; if (bus.fflags !== 5'b00000) begin errors++; $display("FAIL sticky_clear: got %b expected 00000", bus.fflags); end
    bus.fflags_clear = 1'b0;
    drive_op(SQRT_NORMAL, 1'b0, 8'h7F, {24'hB504F3, 1'b1}, 1'b1);
    step();
    checks++; if (bus.fflags !== 5'b00001) begin errors++; $display("FAIL sticky_nx: got %b expected 00001", bus.fflags); end
    drive_op(SQRT_INVALID, 1'b0, 8'h00, 25'd0, 1'b0);
    bus.fflags_clear = 1'b1;
    step();
    checks++; if (bus.fflags !== 5'b10000) begin errors++; $display("FAIL sticky_clear_with_op: got %b expected 10000", bus.fflags); end
    bus.fflags_clear = 1'b0;
    drive_op(SQRT_NORMAL, 1'b0, 8'h7F, {24'hB504F3, 1'b0}, 1'b1);
    step();
    checks++; if (bus.fflags !== 5'b10001) begin errors++; $display("FAIL sticky_accum: got %b expected 10001", bus.fflags); end
    bus.in_valid = 1'b0;
    step();
    // Fill the buffer, then reset while an op is still being offered.
    bus.out_ready = 1'b0;
    drive_op(SQRT_INF, 1'b0, 8'h00, 25'd0, 1'b0);
    step();
    drive_op(SQRT_ZERO, 1'b1, 8'h00, 25'd0, 1'b0);
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_prefill_full: got %b expected 0", bus.in_ready); end
    drive_op(SQRT_INVALID, 1'b0, 8'h00, 25'd0, 1'b0);
    rst = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fflags !== 5'b00000) begin errors++; $display("FAIL rst_flush_fflags: got %b expected 00000", bus.fflags); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    step();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_ghost: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fflags !== 5'b00000) begin errors++; $display("FAIL rst_no_flag_leak: got %b expected 00000", bus.fflags); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_specials();
    test_legacy_nan();
    test_backpressure();
    test_sticky();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/fpu_sqrt_round.md
# fpu_sqrt_round

Rounding and packing stage that sits directly downstream of the square-root mantissa core. It takes the raw root significand, guard bit, remainder-nonzero indication, pre-computed result exponent and operand class. It produces the final IEEE-754 single-precision result under round-to-nearest-even, along with per-operation exception flags and an accumulated sticky flag register. Results are held in a 2-entry output buffer with a valid/ready handshake, so back-pressure from the writeback stage never stalls the core mid-result.

## Interface
- `CANONICAL_NAN`, default 1: selects the invalid-result encoding. 1 = `0x7FC00000`; 0 = `0xFFFFFFFF` (legacy all-ones).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  stage can accept.
- `in_class`  in  3  `sqrt_class_t`, one of NORMAL, ZERO, INF, QNAN, INVALID. INVALID covers negative nonzero operands and sNaN.
- `in_sign`  in  1  operand sign; used only for ZERO.
- `in_exp`  in  8  biased result exponent, 1..254; NORMAL only.
- `in_root`  in  25  `{1.xxx significand[23:0], guard}`. Bit 24 = 1 for NORMAL.
- `in_rem_nz`  in  1  remainder nonzero (sticky).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  32  IEEE single result.
- `out_flags`  out  5  per-op flags `{NV,DZ,OF,UF,NX}`.
- `fflags`  out  5  accumulated sticky flags, same bit order.
- `fflags_clear`  in  1  clear sticky flags.

## Operation
- Accept on `in_valid && in_ready`. Compute the result, push `{result, flags}` into the buffer, and OR the flags into `fflags`.
- NORMAL:
  - Significand bits: `s = in_root[24:1]`, `g = in_root[0]`, `lsb = in_root[1]`.
  - Round up when `g && (in_rem_nz || lsb)`.
  - `s + 1` is computed 25 bits wide. On carry-out: mantissa = 0, exponent = `in_exp + 1`. Exponent overflow cannot occur for legal `in_exp`, so OF is never set.
  - Result = `{0, exp, s_rounded[22:0]}`.
  - NX = `g | in_rem_nz`. All other flags 0.
- ZERO: result `{in_sign, 31'b0}` (sqrt(-0) = -0), flags 0.
- INF: result `0x7F800000`, flags 0.
- QNAN: NaN encoding per `CANONICAL_NAN`, flags 0.
- INVALID: NaN encoding per `CANONICAL_NAN`, NV = 1.
- DZ and UF are always 0.
- Buffer is a 2-entry FIFO, in order.
  - `in_ready = !rst && count < 2`. It does not depend on `out_ready`.
  - `out_valid = count != 0`.
  - `out_result` and `out_flags` show the head entry. They are stable while `out_valid && !out_ready`.
- Push and pop on the same cycle: count unchanged. Push is only possible when `count < 2`.
- `fflags` update at the edge:
  - `fflags_clear` = 0: `fflags <= fflags | newflags`.
  - `fflags_clear` = 1: `fflags <= newflags`. The op accepted that cycle is not lost.
  - `newflags` = 0 when no accept occurs that cycle.

## Timing
- Latency is 1 cycle: an op accepted at edge N appears on `out_valid` after edge N with an empty buffer.
- Throughput is 1 op per cycle while `out_ready = 1`.
- `fflags` reflects an op one cycle after its accept edge.
- Reset state: `count = 0`, `out_valid = 0`, `out_result = 0`, `out_flags = 0`, `fflags = 0`, `in_ready = 0` while `rst` is high, 1 on the first cycle after.
- Reset mid-operation discards all buffered results. In-flight handshakes during `rst` are ignored.

## Structure
- `fpu_pkg` holds:
  - `sqrt_class_t` enum.
  - Flag bit index localparams: NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0.
  - `FP32_QNAN = 32'h7FC00000`, `FP32_PINF = 32'h7F800000`.
- Sub-module `fpu_result_fifo`: 2-entry, 37-bit-wide valid/ready FIFO. The rounding logic stays combinational in the top module, ahead of the FIFO push.

## Test plan
- Exact root: NORMAL, exp `0x83`, root `{24'hC80000, 0}`, `rem_nz` 0 -> `0x41C80000`, flags `00000`.
- Round up: NORMAL, exp `0x7F`, root `{24'hB504F3, 1}`, `rem_nz` 1 -> `0x3FB504F4`, NX. Same input with guard 0 -> `0x3FB504F3`, NX.
- Carry: NORMAL, exp `0x80`, root `{24'hFFFFFF, 1}`, `rem_nz` 1 -> `0x40800000`, NX.
- Specials:
  - INVALID -> `0x7FC00000` with flags `10000` (`CANONICAL_NAN` = 1), or `0xFFFFFFFF` (`CANONICAL_NAN` = 0).
  - ZERO, `in_sign` = 1 -> `0x80000000`.
  - INF -> `0x7F800000`.
- Backpressure: hold `out_ready = 0` and offer 3 ops. `in_ready` drops after 2 accepts and the 3rd is held. Release `out_ready`: all 3 emerge in order, 1 per cycle, head stable while stalled.
- Sticky flags: NX op, then `fflags_clear` in the same cycle as an INVALID accept -> `fflags = 10000`. Assert `rst` with 2 buffered -> `out_valid = 0` and `fflags = 0` on the next cycle.
